div_seq_iter: RTL
=================

Name: div_seq_iter

Overview:
- Iterative integer divider: radix-2^bits_per_cyc restoring, with a valid/ready handshake on input and output.
- Supports unsigned/two's-complement modes, hold, synchronous clear and output backpressure.
- Successor to the fixed-latency combinational-plus-pipeline sequential divider.
- Datapath area is one radix step per clock instead of a full array; sits in the same arithmetic library for control/DSP paths.

Parameters:
- a_width, 16: dividend and quotient width; >= 2.
- b_width, 8: divisor and remainder width; 2 <= b_width <= a_width.
- tc_mode, 0: 0 = unsigned, 1 = two's complement.
- bits_per_cyc, 2: quotient bits resolved per clock; 1..4.
- ITER (derived), ceil(a_width/bits_per_cyc): iteration count.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous abort; drops the operation in flight.
- hold  in  1  freezes CALC/FIX progress.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  a_width  dividend.
- b  in  b_width  divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- quotient  out  a_width  quotient.
- remainder  out  b_width  remainder.
- divide_by_0  out  1  b was zero for this result.
- busy  out  1  state is CALC or FIX.

Behaviour:
- Reset (rst=1, highest priority over everything):
  - state = IDLE.
  - out_valid, busy, divide_by_0 = 0.
  - quotient, remainder = 0.
  - A reset mid-operation discards it.
- clear=1 (rst=0): next state IDLE, out_valid=0, and any pending result is discarded. Quotient/remainder registers keep their values. clear beats an in_valid in the same cycle.
- States:
  - IDLE: in_ready=~hold.
  - CALC: ITER cycles, counter counts ITER-1 down to 0.
  - FIX: 1 cycle; sign correction and load of the output registers.
  - DONE: out_valid=1.
- Accept: an edge with in_valid&in_ready latches a and b and enters CALC.
  - tc_mode=1: latch |a| and |b| and the operand signs.
  - a is zero-extended on the MSB side to ITER*bits_per_cyc bits.
- CALC: each unheld cycle performs bits_per_cyc chained restoring shift-subtract steps, MSB first. After the counter=0 cycle, go to FIX.
- hold=1 in CALC/FIX: state, counter and partial remainder are frozen. hold has no effect in IDLE (except forcing in_ready=0) or in DONE.
- Latency: out_valid rises exactly ITER+1 unheld cycles after the accept edge, including for divide-by-zero. With defaults (ITER=8) that is 9 cycles.
- DONE:
  - Outputs are stable until an edge with out_valid&out_ready.
  - On that edge: if in_valid=1, the new operands are accepted (in_ready=out_ready in DONE, hold ignored) and the state goes straight to CALC. Otherwise the state goes to IDLE.
  - This gives back-to-back throughput of one op per ITER+2 cycles.
- Arithmetic, unsigned: quotient=floor(a/b), remainder=a mod b.
- Arithmetic, signed: quotient truncates toward zero; remainder takes the sign of a; |remainder| < |b|.
  - Overflow case a=-2^(a_width-1), b=-1 gives quotient=-2^(a_width-1) (wrap) and remainder=0. divide_by_0=0.
- Divide-by-zero (b=0): divide_by_0=1 with the result.
  - Unsigned: quotient = all ones.
  - Signed, a>=0: quotient = 2^(a_width-1)-1.
  - Signed, a<0: quotient = -2^(a_width-1).
  - remainder = a[b_width-1:0].
- divide_by_0 is updated only at FIX, together with quotient and remainder.

Test Plan:
- Defaults, unsigned: a=1000, b=7, out_ready=1 -> out_valid exactly 9 cycles after accept; quotient=142, remainder=6, divide_by_0=0.
- tc_mode=1: a=-1000 (0xFC18), b=7 -> quotient=-142 (0xFF72), remainder=-6 (0xFA). Also a=-32768, b=-1 -> quotient=0x8000, remainder=0.
- b=0: unsigned a=0x1234 -> quotient=0xFFFF, remainder=0x34, divide_by_0=1, latency 9. Signed a=5 -> quotient=0x7FFF.
- hold=1 for 3 cycles mid-CALC, plus out_ready=0 for 4 cycles in DONE -> out_valid at cycle 12; outputs stable while stalled; the result is consumed once.
- Back-to-back: in_valid held high with ops (200/3) then (255/16) and out_ready=1 -> results 66 r2 then 15 r15; second accept on the same edge the first result is consumed.
- rst=1 or clear=1 at CALC cycle 4 -> IDLE next cycle, no out_valid; a following op 9/2 yields 4 r1 with normal latency.

Source files
------------

// File: rtl/div_seq_iter.sv
// Iterative restoring divider with a valid/ready handshake on both sides.
// Each clock in CALC resolves bits_per_cyc quotient bits. A single FIX
// cycle then applies the sign correction or the divide-by-zero result and
// loads the output registers.
module div_seq_iter #(
  parameter int a_width      = 16,
  parameter int b_width      = 8,
  parameter int tc_mode      = 0,
  parameter int bits_per_cyc = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               hold,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [a_width-1:0] a,
  input  logic [b_width-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [a_width-1:0] quotient,
  output logic [b_width-1:0] remainder,
  output logic               divide_by_0,
  output logic               busy
);

  localparam int ITER  = (a_width + bits_per_cyc - 1) / bits_per_cyc;
  localparam int EXT   = ITER * bits_per_cyc;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
  localparam bit TC = (tc_mode != 0);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [EXT-1:0]     work, work_init, work_step;
  logic [b_width-1:0] part_rem, rem_step;
  logic [b_width-1:0] b_mag, b_abs, a_low;
  logic [a_width-1:0] a_abs;
  logic               sign_a, sign_b, b_zero;
  logic               accept;
  logic [a_width-1:0] q_fix;
  logic [b_width-1:0] r_fix;

  // State register; reset always returns to IDLE and drops any operation.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs; clear overrides every transition.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: in_ready = ~hold;
      CALC: busy = 1'b1;
      FIX:  busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid && !hold) state_nxt = CALC;
        CALC: if (!hold && cnt == '0) state_nxt = FIX;
        FIX:  if (!hold) state_nxt = DONE;
        DONE: if (out_ready) state_nxt = in_valid ? CALC : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign accept = in_valid & in_ready & ~clear;

  // Operand magnitudes; the dividend is zero-extended to a whole number of radix digits.
  always_comb begin
    a_abs     = (TC && a[a_width-1]) ? (~a + 1'b1) : a;
    b_abs     = (TC && b[b_width-1]) ? (~b + 1'b1) : b;
    work_init = '0;
    work_init[a_width-1:0] = a_abs;
  end

  // One clock of bits_per_cyc chained restoring steps, MSB first; quotient bits shift in at the LSB.
  always_comb begin
    logic [b_width:0] trial;
    trial     = '0;
    work_step = work;
    rem_step  = part_rem;
    for (int i = 0; i < bits_per_cyc; i++) begin
      trial     = {rem_step, work_step[EXT-1]};
      work_step = {work_step[EXT-2:0], 1'b0};
      if (trial >= {1'b0, b_mag}) begin
        trial        = trial - {1'b0, b_mag};
        work_step[0] = 1'b1;
      end
      rem_step = trial[b_width-1:0];
    end
  end

  // Final result: sign correction, or the saturated divide-by-zero value.
  always_comb begin
    q_fix = work[a_width-1:0];
    r_fix = part_rem;
    if (b_zero) begin
      r_fix = a_low;
      if (TC) q_fix = sign_a ? {1'b1, {(a_width-1){1'b0}}} : {1'b0, {(a_width-1){1'b1}}};
      else    q_fix = '1;
    end else begin
      if (sign_a ^ sign_b) q_fix = ~work[a_width-1:0] + 1'b1;
      if (sign_a)          r_fix = ~part_rem + 1'b1;
    end
  end

  // Datapath: latch operands on accept, iterate in CALC, publish in FIX; hold and clear freeze it.
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      divide_by_0 <= 1'b0;
      cnt         <= '0;
      work        <= '0;
      part_rem    <= '0;
      b_mag       <= '0;
      a_low       <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      b_zero      <= 1'b0;
    end else if (accept) begin
      cnt      <= CNT_LAST;
      work     <= work_init;
      part_rem <= '0;
      b_mag    <= b_abs;
      a_low    <= a[b_width-1:0];
      sign_a   <= TC & a[a_width-1];
      sign_b   <= TC & b[b_width-1];
      b_zero   <= (b == '0);
    end else if (!clear && !hold) begin
      if (state == CALC) begin
        work     <= work_step;
        part_rem <= rem_step;
        cnt      <= cnt - 1'b1;
      end else if (state == FIX) begin
        quotient    <= q_fix;
        remainder   <= r_fix;
        divide_by_0 <= b_zero;
      end
    end
  end

endmodule
